alu_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one instance of the combinational `alu` datapath between `NREQ` independent requesters. Each requester presents operands and an opcode with a valid/ready handshake. The block grants one requester at a time, executes the operation on registered operands, and returns the registered result tagged with the requester index. It sits between the issue logic of several functional clients (address generation, compare unit, test harness) and the single shared `alu`.

---
 rtl/alu_pkg.sv | 30 +++
 rtl/alu_arbiter_if.sv | 33 +++
 rtl/alu.sv | 33 +++
 rtl/rr_picker.sv | 41 ++++
 rtl/alu_arbiter.sv | 114 +++++++++++
 tb/tb_alu_arbiter.sv | 207 ++++++++++++++++++++
 6 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU datapath and the alu_arbiter sequencer.
// Contents:
//   - opcode constants understood by alu
//   - ALU_SEL_MAX, the highest legal opcode
//   - arbiter FSM state encoding
//   - sel_legal(), a helper that classifies an opcode as legal or illegal
package alu_pkg;

    localparam logic [3:0] ALU_ADD     = 4'd0;
    localparam logic [3:0] ALU_SUB     = 4'd1;
    localparam logic [3:0] ALU_AND     = 4'd2;
    localparam logic [3:0] ALU_OR      = 4'd3;
    localparam logic [3:0] ALU_XOR     = 4'd4;
    localparam logic [3:0] ALU_NAND    = 4'd5;
    localparam logic [3:0] ALU_NOR     = 4'd6;
    localparam logic [3:0] ALU_MIN_U   = 4'd7;
    localparam logic [3:0] ALU_MIN_S   = 4'd8;
    localparam logic [3:0] ALU_SEL_MAX = 4'd8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } arb_state_t;

    function automatic logic sel_legal(input logic [3:0] sel);
        return sel <= ALU_SEL_MAX;
    endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response bundle between the requesters, the result consumer and
// alu_arbiter. Each requester's operands and opcode are packed side by side:
// requester i uses req_in1/req_in2[i*WIDTH +: WIDTH] and req_sel[i*4 +: 4].
//   master : requester/consumer side (drives requests and rsp_ready)
//   slave  : arbiter side (drives req_ready and the response)
interface alu_arbiter_if #(
    parameter int WIDTH = 32,
    parameter int NREQ  = 4
);
    localparam int IDW = $clog2(NREQ);

    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_in1;
    logic [NREQ*WIDTH-1:0] req_in2;
    logic [NREQ*4-1:0]     req_sel;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [IDW-1:0]        rsp_id;
    logic [WIDTH-1:0]      rsp_out;
    logic                  rsp_err;

    modport master (
        output req_valid, req_in1, req_in2, req_sel, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_out, rsp_err
    );

    modport slave (
        input  req_valid, req_in1, req_in2, req_sel, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_out, rsp_err
    );

endinterface

// File: rtl/alu.sv
// Combinational ALU datapath shared by the arbiter's requesters.
// Ports:
//   in1, in2 : WIDTH-bit operands
//   sel      : opcode (see alu_pkg); 9..15 are illegal and yield zero
//   out      : WIDTH-bit result, arithmetic modulo 2^WIDTH
module alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [3:0]       sel,
    output logic [WIDTH-1:0] out
);

    always_comb begin
        out = '0;
        case (sel)
            ALU_ADD:   out = in1 + in2;
            ALU_SUB:   out = in1 - in2;
            ALU_AND:   out = in1 & in2;
            ALU_OR:    out = in1 | in2;
            ALU_XOR:   out = in1 ^ in2;
            ALU_NAND:  out = ~(in1 & in2);
            ALU_NOR:   out = ~(in1 | in2);
            ALU_MIN_U: out = (in1 < in2) ? in1 : in2;
            ALU_MIN_S: out = ($signed(in1) < $signed(in2)) ? in1 : in2;
            default:   out = '0;
        endcase
    end

endmodule

// File: rtl/rr_picker.sv
// Combinational round-robin picker: finds the first set bit of req searching
// upward from ptr with wrap-around.
// Ports:
//   req     : request vector
//   ptr     : highest-priority index for this pick
//   gnt     : one-hot grant (zero when nothing requested)
//   gnt_idx : binary index of the granted bit
//   any     : at least one request present
module rr_picker #(
    parameter  int NREQ = 4,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  gnt_idx,
    output logic            any
);

    int j;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        j       = 0;
        for (int k = 0; k < NREQ; k++) begin
            // Wrap by subtraction so non-power-of-two NREQ works.
            j = int'(ptr) + k;
            if (j >= NREQ) begin
                j = j - NREQ;
            end
            if (!any && req[j]) begin
                gnt[j]  = 1'b1;
                gnt_idx = IDW'(j);
                any     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter/sequencer sharing one alu between NREQ requesters.
// A granted request's operands are latched, evaluated for one cycle, and the
// result is held tagged with the requester index until the consumer accepts.
// Ports:
//   clk   : clock, all state on the rising edge
//   rst_n : asynchronous active-low reset
//   bus   : alu_arbiter_if slave (requests in, grant and response out)
//
// state   | meaning
// --------+-------------------------------------------
// ST_IDLE | accepting requests, req_ready may be set
// ST_EXEC | alu evaluating latched operands
// ST_RESP | result held until rsp_ready
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int NREQ  = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    alu_arbiter_if.slave  bus
);

    localparam int IDW = $clog2(NREQ);

    arb_state_t       state;
    arb_state_t       state_nxt;
    logic [IDW-1:0]   rr_ptr;
    logic [IDW-1:0]   tag;
    logic [NREQ-1:0]  gnt;
    logic [IDW-1:0]   gnt_idx;
    logic             any;
    logic             accept;
    logic [WIDTH-1:0] op1;
    logic [WIDTH-1:0] op2;
    logic [3:0]       op_sel;
    logic [WIDTH-1:0] alu_out;
    logic [WIDTH-1:0] rsp_out_q;
    logic             rsp_err_q;

    rr_picker #(.NREQ(NREQ)) u_picker (
        .req     (bus.req_valid),
        .ptr     (rr_ptr),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .any     (any)
    );

    alu #(.WIDTH(WIDTH)) u_alu (
        .in1 (op1),
        .in2 (op2),
        .sel (op_sel),
        .out (alu_out)
    );

    assign accept = (state == ST_IDLE) && any;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (any) state_nxt = ST_EXEC;
            ST_EXEC: state_nxt = ST_RESP;
            ST_RESP: if (bus.rsp_ready) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr    <= '0;
            tag       <= '0;
            op1       <= '0;
            op2       <= '0;
            op_sel    <= '0;
            rsp_out_q <= '0;
            rsp_err_q <= 1'b0;
        end else begin
            if (accept) begin
                op1    <= bus.req_in1[int'(gnt_idx)*WIDTH +: WIDTH];
                op2    <= bus.req_in2[int'(gnt_idx)*WIDTH +: WIDTH];
                op_sel <= bus.req_sel[int'(gnt_idx)*4 +: 4];
                tag    <= gnt_idx;
                rr_ptr <= (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + IDW'(1);
            end
            if (state == ST_EXEC) begin
                // Illegal opcodes report an error with a clean zero result.
                if (sel_legal(op_sel)) begin
                    rsp_out_q <= alu_out;
                    rsp_err_q <= 1'b0;
                end else begin
                    rsp_out_q <= '0;
                    rsp_err_q <= 1'b1;
                end
            end
        end
    end

    // Grant only in IDLE and never while reset is held; no rsp_ready path.
    assign bus.req_ready = (state == ST_IDLE && rst_n) ? gnt : '0;
    assign bus.rsp_valid = (state == ST_RESP);
    assign bus.rsp_id    = tag;
    assign bus.rsp_out   = rsp_out_q;
    assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;
    import alu_pkg::*;

    localparam int WIDTH = 32;
    localparam int NREQ  = 4;

    typedef struct {
        int          id;
        logic [3:0]  sel;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        logic        err;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;
    vec_t vecs[14];

    always #5 clk = ~clk;

    alu_arbiter_if #(.WIDTH(WIDTH), .NREQ(NREQ)) bus ();

    alu_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input int id, input logic [3:0] sel,
                             input logic [31:0] a, input logic [31:0] b);
        bus.req_in1[id*WIDTH +: WIDTH] = a;
        bus.req_in2[id*WIDTH +: WIDTH] = b;
        bus.req_sel[id*4 +: 4]         = sel;
        bus.req_valid[id]              = 1'b1;
    endtask

    // Full single-request transaction; entered 1 time unit after an edge in IDLE
    // with rsp_ready high, leaves the same way.
    task automatic run_op(input string nm, input int id, input logic [3:0] sel,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input logic err);
        drive_req(id, sel, a, b);
        #1;
        check({nm, "_ready"}, 64'(bus.req_ready), 64'(1) << id);
        tick();
        bus.req_valid[id] = 1'b0;
        check({nm, "_exec_valid"}, 64'(bus.rsp_valid), 64'd0);
        tick();
        check({nm, "_valid"}, 64'(bus.rsp_valid), 64'd1);
        check({nm, "_out"}, 64'(bus.rsp_out), 64'(exp));
        check({nm, "_id"}, 64'(bus.rsp_id), 64'(id));
        check({nm, "_err"}, 64'(bus.rsp_err), 64'(err));
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{0,  ALU_SUB,   32'h0000_0003, 32'h0000_0005, 32'hFFFF_FFFE, 1'b0};
        vecs[1]  = '{1,  ALU_AND,   32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200, 1'b0};
        vecs[2]  = '{3,  ALU_OR,    32'hA000_0001, 32'h0500_0010, 32'hA500_0011, 1'b0};
        vecs[3]  = '{2,  ALU_XOR,   32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F, 1'b0};
        vecs[4]  = '{0,  ALU_NAND,  32'hFFFF_FFFF, 32'h0000_FFFF, 32'hFFFF_0000, 1'b0};
        vecs[5]  = '{1,  ALU_NOR,   32'h0000_00F0, 32'h0000_000F, 32'hFFFF_FF00, 1'b0};
        vecs[6]  = '{3,  ALU_MIN_U, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0};
        vecs[7]  = '{2,  ALU_MIN_S, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0};
        vecs[8]  = '{0,  4'd12,     32'h0000_0003, 32'h0000_0004, 32'h0000_0000, 1'b1};
        vecs[9]  = '{1,  4'd15,     32'h1234_5678, 32'h0000_0001, 32'h0000_0000, 1'b1};
        vecs[10] = '{3,  ALU_ADD,   32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 1'b0};
        vecs[11] = '{1,  ALU_MIN_S, 32'h8000_0000, 32'h7FFF_FFFF, 32'h8000_0000, 1'b0};
        vecs[12] = '{0,  ALU_MIN_U, 32'h8000_0000, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0};
        vecs[13] = '{2,  4'd9,      32'h0000_0001, 32'h0000_0001, 32'h0000_0000, 1'b1};

        bus.req_valid = '0;
        bus.req_in1   = '0;
        bus.req_in2   = '0;
        bus.req_sel   = '0;
        bus.rsp_ready = 1'b0;

        // Reset state, with requests present to show req_ready stays low.
        rst_n = 1'b0;
        bus.req_valid = '1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_req_ready", 64'(bus.req_ready), 64'd0);
        check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check("rst_rsp_out",   64'(bus.rsp_out),   64'd0);
        check("rst_rsp_id",    64'(bus.rsp_id),    64'd0);
        check("rst_rsp_err",   64'(bus.rsp_err),   64'd0);
        check("rst_rr_ptr",    64'(dut.rr_ptr),    64'd0);
        bus.req_valid = '0;
        rst_n = 1'b1;
        bus.rsp_ready = 1'b1;

        // Single request from requester 2.
        run_op("single_add", 2, ALU_ADD, 32'd5, 32'd7, 32'd12, 1'b0);
        check("single_rr_ptr", 64'(dut.rr_ptr), 64'd3);

        // Table of independent single-requester operations.
        for (int i = 0; i < 14; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].id, vecs[i].sel,
                   vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].err);
        end

        // Round robin from a fresh reset with all four requesting.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            drive_req(i, ALU_ADD, 32'(i * 16), 32'(i + 1));
        end
        for (int g = 0; g < 5; g++) begin
            int e;
            e = g % NREQ;
            #1;
            check($sformatf("rr%0d_ready", g), 64'(bus.req_ready), 64'(1) << e);
            tick();
            tick();
            check($sformatf("rr%0d_valid", g), 64'(bus.rsp_valid), 64'd1);
            check($sformatf("rr%0d_id", g),    64'(bus.rsp_id),    64'(e));
            check($sformatf("rr%0d_out", g),   64'(bus.rsp_out),   64'(e * 16 + e + 1));
            tick();
        end
        bus.req_valid = '0;

        // Backpressure: rr_ptr is 1 here, so requester 1 wins over 3.
        bus.rsp_ready = 1'b0;
        drive_req(1, ALU_XOR, 32'h1234_5678, 32'hFFFF_0000);
        drive_req(3, ALU_ADD, 32'd1, 32'd1);
        #1;
        check("bp_ready", 64'(bus.req_ready), 64'd2);
        tick();
        bus.req_valid[1] = 1'b0;
        tick();
        for (int c = 0; c < 5; c++) begin
            check($sformatf("bp%0d_valid", c), 64'(bus.rsp_valid), 64'd1);
            check($sformatf("bp%0d_out", c),   64'(bus.rsp_out),   64'hEDCB_5678);
            check($sformatf("bp%0d_id", c),    64'(bus.rsp_id),    64'd1);
            check($sformatf("bp%0d_ready", c), 64'(bus.req_ready), 64'd0);
            tick();
        end
        bus.rsp_ready = 1'b1;
        tick();
        check("bp_release_ready", 64'(bus.req_ready), 64'd8);
        tick();
        bus.req_valid[3] = 1'b0;
        tick();
        check("bp_next_valid", 64'(bus.rsp_valid), 64'd1);
        check("bp_next_out",   64'(bus.rsp_out),   64'd2);
        check("bp_next_id",    64'(bus.rsp_id),    64'd3);
        tick();

        // Async reset while requester 1's operation is in EXEC.
        drive_req(1, ALU_ADD, 32'd9, 32'd9);
        #1;
        check("ar_ready", 64'(bus.req_ready), 64'd2);
        tick();
        bus.req_valid[1] = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_valid_now", 64'(bus.rsp_valid), 64'd0);
        check("ar_rr_ptr",    64'(dut.rr_ptr),    64'd0);
        drive_req(0, ALU_SUB, 32'd10, 32'd3);
        drive_req(1, ALU_ADD, 32'd9, 32'd9);
        for (int c = 0; c < 3; c++) begin
            tick();
            check($sformatf("ar%0d_valid", c), 64'(bus.rsp_valid), 64'd0);
        end
        rst_n = 1'b1;
        #1;
        check("ar_post_rr_ptr", 64'(dut.rr_ptr),    64'd0);
        check("ar_post_ready",  64'(bus.req_ready), 64'd1);
        tick();
        bus.req_valid = '0;
        check("ar_post_exec_valid", 64'(bus.rsp_valid), 64'd0);
        tick();
        check("ar_post_valid", 64'(bus.rsp_valid), 64'd1);
        check("ar_post_id",    64'(bus.rsp_id),    64'd0);
        check("ar_post_out",   64'(bus.rsp_out),   64'd7);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
